// File: rtl/logic_block_config_loader_if.sv
// Bus bundle between a configuration bitstream source and the logic block
// configuration loader: serial bit handshake, write port and status.
interface logic_block_config_loader_if;
    logic        cfg_bit;
    logic        cfg_bit_valid;
    logic        cfg_bit_ready;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [6:0]  cfg_data;
    logic [15:0] loaded_map;
    logic        all_loaded;
    logic        err;
    logic [1:0]  err_code;
    logic        err_clr;
    logic [7:0]  frame_cnt;

    modport master (
        output cfg_bit, cfg_bit_valid, err_clr,
        input  cfg_bit_ready, cfg_we, cfg_addr, cfg_data, loaded_map,
               all_loaded, err, err_code, frame_cnt
    );

    modport slave (
        input  cfg_bit, cfg_bit_valid, err_clr,
        output cfg_bit_ready, cfg_we, cfg_addr, cfg_data, loaded_map,
               all_loaded, err, err_code, frame_cnt
    );
endinterface

// File: rtl/logic_block_config_loader.sv
// Serial configuration loader: hunts for the A5 sync byte, gathers addr /
// route_sel / lut / chk fields, validates them and writes one logic block.
module logic_block_config_loader #(
    parameter int NUM_BLOCKS = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    logic_block_config_loader_if.slave    bus
);

    localparam logic [2:0]  ST_HUNT  = 3'd0;
    localparam logic [2:0]  ST_ADDR  = 3'd1;
    localparam logic [2:0]  ST_DATA  = 3'd2;
    localparam logic [2:0]  ST_CHECK = 3'd3;
    localparam logic [2:0]  ST_WRITE = 3'd4;
    localparam logic [7:0]  SYNC     = 8'hA5;
    localparam logic [4:0]  NB       = 5'(NUM_BLOCKS);
    localparam logic [15:0] MAP_MASK = 16'((32'd1 << NUM_BLOCKS) - 32'd1);

    function automatic logic [3:0] frame_chk(input logic [3:0] a,
                                             input logic [2:0] rs,
                                             input logic [3:0] lut);
        return a ^ lut ^ {1'b0, rs};
    endfunction

    logic [2:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  win_q, win_d;
    logic [3:0]  addr_q, addr_d;
    logic [6:0]  data_q, data_d;
    logic [3:0]  chk_q, chk_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [3:0]  cfg_addr_q, cfg_addr_d;
    logic [6:0]  cfg_data_q, cfg_data_d;
    logic [15:0] map_q, map_d;
    logic        all_q, all_d;
    logic        err_q, err_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  fcnt_q, fcnt_d;
    logic        accept_s;

    assign accept_s = bus.cfg_bit_valid & ready_q;

    // Next-state, field assembly, frame evaluation and status update
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        addr_d     = addr_q;
        data_d     = data_q;
        chk_d      = chk_q;
        we_d       = 1'b0;
        cfg_addr_d = cfg_addr_q;
        cfg_data_d = cfg_data_q;
        map_d      = map_q;
        fcnt_d     = fcnt_q;
        if (bus.err_clr) begin
            err_d  = 1'b0;
            code_d = 2'b00;
        end else begin
            err_d  = err_q;
            code_d = code_q;
        end

        case (state_q)
            ST_HUNT: begin
                if (accept_s) begin
                    win_d = {win_q[6:0], bus.cfg_bit};
                    if (win_d == SYNC) begin
                        state_d = ST_ADDR;
                        cnt_d   = 3'd0;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end else begin
                    state_d = ST_HUNT;
                end
            end
            ST_ADDR: begin
                if (accept_s) begin
                    addr_d = {addr_q[2:0], bus.cfg_bit};
                    if (cnt_q == 3'd3) begin
                        state_d = ST_DATA;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    data_d = {data_q[5:0], bus.cfg_bit};
                    if (cnt_q == 3'd6) begin
                        state_d = ST_CHECK;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHECK: begin
                // cnt_q == 4 marks the evaluation cycle (ready held low)
                if (cnt_q == 3'd4) begin
                    cnt_d = 3'd0;
                    if (chk_q != frame_chk(addr_q, data_q[6:4], data_q[3:0])) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = ST_HUNT;
                        win_d   = 8'h00;
                    end else if (data_q[6:5] == 2'b11) begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = ST_HUNT;
                        win_d   = 8'h00;
                    end else if ({1'b0, addr_q} >= NB) begin
                        err_d   = 1'b1;
                        code_d  = 2'b11;
                        state_d = ST_HUNT;
                        win_d   = 8'h00;
                    end else begin
                        state_d    = ST_WRITE;
                        we_d       = 1'b1;
                        cfg_addr_d = addr_q;
                        cfg_data_d = data_q;
                    end
                end else if (accept_s) begin
                    chk_d = {chk_q[2:0], bus.cfg_bit};
                    cnt_d = cnt_q + 3'd1;
                end else begin
                    state_d = ST_CHECK;
                end
            end
            ST_WRITE: begin
                map_d = map_q | (16'h0001 << cfg_addr_q);
                if (fcnt_q != 8'hFF) begin
                    fcnt_d = fcnt_q + 8'd1;
                end else begin
                    fcnt_d = fcnt_q;
                end
                state_d = ST_HUNT;
                win_d   = 8'h00;
                cnt_d   = 3'd0;
            end
            default: begin
                state_d = ST_HUNT;
                win_d   = 8'h00;
                cnt_d   = 3'd0;
            end
        endcase

        ready_d = !((state_d == ST_WRITE) || ((state_d == ST_CHECK) && (cnt_d == 3'd4)));
        all_d   = ((map_d & MAP_MASK) == MAP_MASK);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HUNT;
            cnt_q      <= 3'd0;
            win_q      <= 8'h00;
            addr_q     <= 4'h0;
            data_q     <= 7'h00;
            chk_q      <= 4'h0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            cfg_addr_q <= 4'h0;
            cfg_data_q <= 7'h00;
            map_q      <= 16'h0000;
            all_q      <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= 2'b00;
            fcnt_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            chk_q      <= chk_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            cfg_addr_q <= cfg_addr_d;
            cfg_data_q <= cfg_data_d;
            map_q      <= map_d;
            all_q      <= all_d;
            err_q      <= err_d;
            code_q     <= code_d;
            fcnt_q     <= fcnt_d;
        end
    end

    assign bus.cfg_bit_ready = ready_q;
    assign bus.cfg_we        = we_q;
    assign bus.cfg_addr      = cfg_addr_q;
    assign bus.cfg_data      = cfg_data_q;
    assign bus.loaded_map    = map_q;
    assign bus.all_loaded    = all_q;
    assign bus.err           = err_q;
    assign bus.err_code      = code_q;
    assign bus.frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_logic_block_config_loader.sv
// Self-checking bench: randomized bitstreams with valid gaps, checked against a
// frame-parsing reference model, on a 16-block and an 8-block loader.
module tb_logic_block_config_loader;

    logic clk     = 1'b0;
    logic rst_n16 = 1'b0;
    logic rst_n8  = 1'b0;
    always #5 clk = ~clk;

    logic_block_config_loader_if if16 ();
    logic_block_config_loader_if if8 ();

    logic_block_config_loader #(.NUM_BLOCKS(16)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n16),
        .bus   (if16.slave)
    );

    logic_block_config_loader #(.NUM_BLOCKS(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n8),
        .bus   (if8.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit          stim[$];
    logic [10:0] exp_w[$];
    logic [10:0] got16[$];
    logic [10:0] got8[$];
    int          we_cnt8   = 0;
    logic        prev_we16 = 1'b0;
    logic        al_at_we  = 1'b0;
    logic        al_after  = 1'b0;

    logic [15:0] m_map  [2];
    int          m_cnt  [2];
    logic        m_err  [2];
    logic [1:0]  m_code [2];

    // Write-strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (prev_we16) al_after = if16.all_loaded;
        if (if16.cfg_we === 1'b1) begin
            got16.push_back({if16.cfg_addr, if16.cfg_data});
            al_at_we = if16.all_loaded;
        end
        prev_we16 = (if16.cfg_we === 1'b1);
        if (if8.cfg_we === 1'b1) begin
            got8.push_back({if8.cfg_addr, if8.cfg_data});
            we_cnt8++;
        end
    end

    function automatic logic [3:0] good_chk(input logic [3:0] a, input logic [2:0] rs,
                                            input logic [3:0] lut);
        return a ^ lut ^ {1'b0, rs};
    endfunction

    task automatic push_bits(input logic [7:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) stim.push_back(v[i]);
    endtask

    task automatic push_frame(input logic [3:0] a, input logic [2:0] rs,
                              input logic [3:0] lut, input logic [3:0] ck);
        push_bits(8'hA5, 8);
        push_bits({4'h0, a}, 4);
        push_bits({5'h00, rs}, 3);
        push_bits({4'h0, lut}, 4);
        push_bits({4'h0, ck}, 4);
    endtask

    task automatic model_reset(input int d);
        m_map[d]  = 16'h0000;
        m_cnt[d]  = 0;
        m_err[d]  = 1'b0;
        m_code[d] = 2'b00;
    endtask

    // Reference: scan the bit list for A5, slice out fields, apply the frame rules
    task automatic model_run(input int d, input int nb);
        logic [7:0] win;
        int         i;
        logic [3:0] a, lut, ck;
        logic [2:0] rs;
        logic [1:0] code;
        win = 8'h00;
        i   = 0;
        while (i < stim.size()) begin
            win = {win[6:0], stim[i]};
            i++;
            if (win == 8'hA5 && i + 15 <= stim.size()) begin
                a   = {stim[i], stim[i+1], stim[i+2], stim[i+3]};
                rs  = {stim[i+4], stim[i+5], stim[i+6]};
                lut = {stim[i+7], stim[i+8], stim[i+9], stim[i+10]};
                ck  = {stim[i+11], stim[i+12], stim[i+13], stim[i+14]};
                i   = i + 15;
                win = 8'h00;
                if (ck != (a ^ lut ^ {1'b0, rs})) code = 2'd1;
                else if (rs > 3'd5)               code = 2'd2;
                else if (int'(a) >= nb)           code = 2'd3;
                else                              code = 2'd0;
                if (code != 2'd0) begin
                    m_err[d]  = 1'b1;
                    m_code[d] = code;
                end else begin
                    exp_w.push_back({a, rs, lut});
                    m_map[d][a] = 1'b1;
                    if (m_cnt[d] < 255) m_cnt[d]++;
                end
            end
        end
    endtask

    task automatic set_in(input int d, input logic v, input logic b);
        if (d == 0) begin
            if16.cfg_bit_valid = v;
            if16.cfg_bit       = b;
        end else begin
            if8.cfg_bit_valid = v;
            if8.cfg_bit       = b;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? if16.cfg_bit_ready : if8.cfg_bit_ready;
    endfunction

    task automatic drive(input int d, input int maxgap);
        int tmo;
        foreach (stim[k]) begin
            repeat ($urandom_range(maxgap, 0)) begin
                @(negedge clk);
                set_in(d, 1'b0, 1'b0);
            end
            @(negedge clk);
            set_in(d, 1'b1, stim[k]);
            tmo = 0;
            while (rdy(d) !== 1'b1 && tmo < 20) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo >= 20) begin
                n_cmp++;
                n_bad++;
                $display("FAIL drive_timeout: cfg_bit_ready=%b, required 1 within 20 cycles", rdy(d));
            end
        end
        @(negedge clk);
        set_in(d, 1'b0, 1'b0);
    endtask

    task automatic run_stim(input int d, input int nb, input int maxgap);
        model_run(d, nb);
        drive(d, maxgap);
        repeat (4) @(negedge clk);
        stim.delete();
    endtask

    task automatic test_reset();
        set_in(0, 1'b0, 1'b0);
        set_in(1, 1'b0, 1'b0);
        if16.err_clr = 1'b0;
        if8.err_clr  = 1'b0;
        rst_n16 = 1'b0;
        rst_n8  = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({if16.cfg_bit_ready, if16.cfg_we, if16.cfg_addr, if16.cfg_data, if16.loaded_map,
             if16.all_loaded, if16.err, if16.err_code, if16.frame_cnt} !== 41'd0) begin
            n_bad++;
            $display("FAIL reset16_outputs: ready=%b we=%b map=%h err=%b code=%b cnt=%0d, required all 0",
                     if16.cfg_bit_ready, if16.cfg_we, if16.loaded_map, if16.err, if16.err_code, if16.frame_cnt);
        end
        rst_n16 = 1'b1;
        rst_n8  = 1'b1;
        #1;
        n_cmp++;
        if (if16.cfg_bit_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_before_edge: got %b, required 0", if16.cfg_bit_ready);
        end
        @(negedge clk);
        n_cmp++;
        if ({if16.cfg_bit_ready, if8.cfg_bit_ready} !== 2'b11) begin
            n_bad++;
            $display("FAIL ready_after_edge: got %b%b, required 11", if16.cfg_bit_ready, if8.cfg_bit_ready);
        end
        model_reset(0);
        model_reset(1);
    endtask

    task automatic test_good_frame();
        got16.delete();
        exp_w.delete();
        push_frame(4'h3, 3'b100, 4'b0110, 4'b0001);
        run_stim(0, 16, 0);
        n_cmp++;
        if (got16.size() != 1 || got16[0] !== {4'h3, 7'b1000110}) begin
            n_bad++;
            $display("FAIL good_write: got %0d writes first=%h, required 1 write of %h",
                     got16.size(), (got16.size() > 0) ? got16[0] : 11'h0, {4'h3, 7'b1000110});
        end
        n_cmp++;
        if (if16.loaded_map !== 16'h0008 || if16.frame_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL good_status: map=%h cnt=%0d, required 0008 / 1", if16.loaded_map, if16.frame_cnt);
        end
    endtask

    task automatic test_bad_chk();
        got16.delete();
        exp_w.delete();
        push_frame(4'h3, 3'b100, 4'b0110, 4'b0000);
        run_stim(0, 16, 1);
        n_cmp++;
        if (got16.size() != 0 || if16.err !== 1'b1 || if16.err_code !== 2'b01 || if16.frame_cnt !== 8'd1) begin
            n_bad++;
            $display("FAIL chk_error: writes=%0d err=%b code=%b cnt=%0d, required 0 / 1 / 01 / 1",
                     got16.size(), if16.err, if16.err_code, if16.frame_cnt);
        end
        @(negedge clk);
        if16.err_clr = 1'b1;
        @(negedge clk);
        if16.err_clr = 1'b0;
        m_err[0]  = 1'b0;
        m_code[0] = 2'b00;
        n_cmp++;
        if (if16.err !== 1'b0 || if16.err_code !== 2'b00) begin
            n_bad++;
            $display("FAIL err_clr: err=%b code=%b, required 0 / 00", if16.err, if16.err_code);
        end
    endtask

    task automatic test_junk_sync();
        logic [3:0] a, lut;
        logic [2:0] rs;
        got16.delete();
        exp_w.delete();
        a   = 4'($urandom_range(14, 0));
        rs  = 3'($urandom_range(5, 0));
        lut = 4'($urandom_range(15, 0));
        push_bits(8'hFF, 8);
        push_bits(8'hA4, 8);
        push_frame(a, rs, lut, good_chk(a, rs, lut));
        run_stim(0, 16, 3);
        n_cmp++;
        if (got16.size() != 1 || got16[0] !== {a, rs, lut} || exp_w.size() != 1) begin
            n_bad++;
            $display("FAIL junk_sync: got %0d writes first=%h, required 1 write of %h",
                     got16.size(), (got16.size() > 0) ? got16[0] : 11'h0, {a, rs, lut});
        end
        n_cmp++;
        if (if16.loaded_map !== m_map[0] || int'(if16.frame_cnt) != m_cnt[0]) begin
            n_bad++;
            $display("FAIL junk_status: map=%h cnt=%0d, required %h / %0d",
                     if16.loaded_map, if16.frame_cnt, m_map[0], m_cnt[0]);
        end
    endtask

    task automatic test_fill_map();
        logic [3:0] a, lut;
        logic [2:0] rs;
        got16.delete();
        exp_w.delete();
        for (int k = 0; k < 16; k++) begin
            a   = 4'(k);
            rs  = 3'($urandom_range(5, 0));
            lut = 4'($urandom_range(15, 0));
            push_frame(a, rs, lut, good_chk(a, rs, lut));
        end
        run_stim(0, 16, 1);
        n_cmp++;
        if (got16.size() != 16 || got16 != exp_w) begin
            n_bad++;
            $display("FAIL fill_writes: got %0d writes, required 16 matching the model", got16.size());
        end
        n_cmp++;
        if (al_at_we !== 1'b0 || al_after !== 1'b1 || if16.loaded_map !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL fill_all_loaded: at_we=%b after=%b map=%h, required 0 / 1 / ffff",
                     al_at_we, al_after, if16.loaded_map);
        end
        n_cmp++;
        if (int'(if16.frame_cnt) != m_cnt[0]) begin
            n_bad++;
            $display("FAIL fill_cnt: got %0d, required %0d", if16.frame_cnt, m_cnt[0]);
        end
        got16.delete();
        exp_w.delete();
        a   = 4'($urandom_range(15, 0));
        lut = 4'($urandom_range(15, 0));
        push_frame(a, 3'b111, lut, good_chk(a, 3'b111, lut));
        run_stim(0, 16, 1);
        n_cmp++;
        if (got16.size() != 0 || if16.err_code !== 2'b10 || if16.loaded_map !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL route_illegal: writes=%0d code=%b map=%h, required 0 / 10 / ffff",
                     got16.size(), if16.err_code, if16.loaded_map);
        end
    endtask

    task automatic test_random();
        logic [3:0] a, lut, ck;
        logic [2:0] rs;
        got16.delete();
        exp_w.delete();
        for (int k = 0; k < 12; k++) begin
            a   = 4'($urandom_range(15, 0));
            rs  = 3'($urandom_range(7, 0));
            lut = 4'($urandom_range(15, 0));
            ck  = ($urandom_range(3, 0) == 0) ? 4'($urandom_range(15, 0)) : good_chk(a, rs, lut);
            push_frame(a, rs, lut, ck);
        end
        run_stim(0, 16, 2);
        n_cmp++;
        if (got16 != exp_w) begin
            n_bad++;
            $display("FAIL random_writes: got %0d writes, required %0d matching the model",
                     got16.size(), exp_w.size());
        end
        n_cmp++;
        if (int'(if16.frame_cnt) != m_cnt[0] || if16.err !== m_err[0] || if16.err_code !== m_code[0]) begin
            n_bad++;
            $display("FAIL random_status: cnt=%0d err=%b code=%b, required %0d / %b / %b",
                     if16.frame_cnt, if16.err, if16.err_code, m_cnt[0], m_err[0], m_code[0]);
        end
    endtask

    task automatic test_nb8_range();
        logic [2:0] rs;
        logic [3:0] lut;
        got8.delete();
        exp_w.delete();
        rs  = 3'($urandom_range(5, 0));
        lut = 4'($urandom_range(15, 0));
        push_frame(4'd7, rs, lut, good_chk(4'd7, rs, lut));
        push_frame(4'd9, rs, lut, good_chk(4'd9, rs, lut));
        run_stim(1, 8, 1);
        n_cmp++;
        if (got8.size() != 1 || got8[0] !== {4'd7, rs, lut} || got8 != exp_w) begin
            n_bad++;
            $display("FAIL nb8_writes: got %0d writes, required 1 write to addr 7", got8.size());
        end
        n_cmp++;
        if (if8.err !== 1'b1 || if8.err_code !== 2'b11 || if8.loaded_map !== 16'h0080 || if8.all_loaded !== 1'b0) begin
            n_bad++;
            $display("FAIL nb8_range: err=%b code=%b map=%h all=%b, required 1 / 11 / 0080 / 0",
                     if8.err, if8.err_code, if8.loaded_map, if8.all_loaded);
        end
    endtask

    task automatic test_reset_midframe();
        int we_before;
        we_before = we_cnt8;
        got8.delete();
        exp_w.delete();
        push_bits(8'hA5, 8);
        push_bits(8'h02, 4);
        drive(1, 1);
        stim.delete();
        rst_n8 = 1'b0;
        #1;
        n_cmp++;
        if ({if8.cfg_bit_ready, if8.cfg_we, if8.cfg_addr, if8.cfg_data, if8.loaded_map,
             if8.all_loaded, if8.err, if8.err_code, if8.frame_cnt} !== 41'd0) begin
            n_bad++;
            $display("FAIL midframe_reset: ready=%b map=%h err=%b code=%b cnt=%0d, required all 0",
                     if8.cfg_bit_ready, if8.loaded_map, if8.err, if8.err_code, if8.frame_cnt);
        end
        @(negedge clk);
        rst_n8 = 1'b1;
        model_reset(1);
        push_bits(8'h01, 3);
        push_bits(8'h0A, 4);
        push_bits({4'h0, good_chk(4'h2, 3'b001, 4'b1010)}, 4);
        run_stim(1, 8, 0);
        n_cmp++;
        if (we_cnt8 != we_before || exp_w.size() != 0 || if8.frame_cnt !== 8'd0 || if8.loaded_map !== 16'h0000) begin
            n_bad++;
            $display("FAIL midframe_nowrite: writes=%0d cnt=%0d map=%h, required 0 / 0 / 0000",
                     we_cnt8 - we_before, if8.frame_cnt, if8.loaded_map);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_junk_sync();
        test_fill_map();
        test_random();
        test_nb8_range();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
